// File: rtl/cpu_pkg.sv
// Shared definitions for the memory image loader: target codes, word width
// and the loader state encoding.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] TGT_IMEM = 8'h49;  // 'I'
    localparam logic [7:0] TGT_DMEM = 8'h44;  // 'D'
    localparam logic [7:0] TGT_END  = 8'h00;  // stream terminator

    typedef enum logic [2:0] {
        ST_TGT,
        ST_HDR,
        ST_DATA,
        ST_RUN,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/mem_image_loader_byte_word_assembler.sv
// Collects four bytes, first byte most significant, into a 32-bit word.
// word/word_valid are combinational so the caller can act on the same
// handshake that delivers the fourth byte.
module byte_word_assembler
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    assign word       = {shreg, byte_data};
    assign word_valid = byte_valid && (byte_cnt == 2'd3);

    // Shift in accepted bytes; the counter wraps every four bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            shreg    <= {shreg[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/mem_image_loader.sv
// Streaming imem/dmem image loader. Parses [target][addr16][cnt16][words]
// segments, issues one-cycle write strobes, and holds the core in reset
// until the terminator arrives.
module mem_image_loader
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    loader_state_t     state;
    logic              is_dmem;
    logic [15:0]       addr;
    logic [15:0]       cnt;

    logic              asm_en;
    logic [WORD_W-1:0] asm_word;
    logic              asm_done;
    logic [16:0]       seg_end;
    logic [16:0]       depth;

    // Header and data bytes both go through the assembler; every entry into
    // HDR or DATA happens on a four-byte boundary, so its counter is aligned.
    assign asm_en = in_valid && in_ready && (state == ST_HDR || state == ST_DATA);

    byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (asm_en),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_valid (asm_done)
    );

    assign seg_end = {1'b0, asm_word[31:16]} + {1'b0, asm_word[15:0]};
    assign depth   = is_dmem ? 17'(DMEM_DEPTH) : 17'(IMEM_DEPTH);

    // Loader FSM with registered handshake, strobe and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_TGT;
            is_dmem   <= 1'b0;
            addr      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            case (state)
                ST_TGT: begin
                    if (in_valid) begin
                        if (in_data == TGT_END) begin
                            state     <= ST_RUN;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else if (in_data == TGT_IMEM || in_data == TGT_DMEM) begin
                            is_dmem <= (in_data == TGT_DMEM);
                            state   <= ST_HDR;
                        end else begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (asm_done) begin
                        addr <= asm_word[31:16];
                        cnt  <= asm_word[15:0];
                        if (seg_end > depth) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else if (asm_word[15:0] == 16'd0) begin
                            state <= ST_TGT;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (asm_done) begin
                        imem_we   <= !is_dmem;
                        dmem_we   <= is_dmem;
                        mem_addr  <= addr[ADDR_W-1:0];
                        mem_wdata <= asm_word;
                        addr      <= addr + 16'd1;
                        cnt       <= cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            state <= ST_TGT;
                        end
                    end
                end
                default: begin
                    // RUN and ERR are terminal until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader. Each stream is parsed up front into
// a table of expected writes and terminal events; a per-cycle compare
// process checks all outputs against that expectation.
module tb_mem_image_loader;

    localparam int IMEM_DEPTH = 256;
    localparam int DMEM_DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic        dmem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    mem_image_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .ADDR_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream model ----------------
    logic [7:0]  strm[$];
    bit          wr_v[64];
    bit          wr_d[64];
    logic [7:0]  wr_a[64];
    logic [31:0] wr_w[64];
    int          term_at;
    int          err_at;

    function automatic void parse();
        int p = 0;
        int a, c, depth;
        for (int i = 0; i < 64; i++) wr_v[i] = 1'b0;
        term_at = -1;
        err_at  = -1;
        while (p < strm.size()) begin
            if (strm[p] == 8'h00) begin term_at = p; return; end
            if (strm[p] != 8'h49 && strm[p] != 8'h44) begin err_at = p; return; end
            if (p + 4 >= strm.size()) return;
            a = {strm[p+1], strm[p+2]};
            c = {strm[p+3], strm[p+4]};
            depth = (strm[p] == 8'h44) ? DMEM_DEPTH : IMEM_DEPTH;
            if (a + c > depth) begin err_at = p + 4; return; end
            for (int w = 0; w < c; w++) begin
                int q = p + 5 + 4 * w;
                if (q + 3 >= strm.size()) return;
                wr_v[q+3] = 1'b1;
                wr_d[q+3] = (strm[p] == 8'h44);
                wr_a[q+3] = 8'((a + w) % 256);
                wr_w[q+3] = {strm[q], strm[q+1], strm[q+2], strm[q+3]};
            end
            p = p + 5 + 4 * c;
        end
    endfunction

    // Expected outputs for the current cycle.
    logic        exp_ready, exp_iwe, exp_dwe, exp_crst, exp_done, exp_err;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    bit          checking = 1'b0;

    function automatic void exp_reset();
        exp_ready = 1'b1; exp_iwe = 1'b0; exp_dwe = 1'b0; exp_crst = 1'b1;
        exp_done = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
    endfunction

    function automatic void accept(input int k);
        if (wr_v[k]) begin
            exp_iwe  = !wr_d[k];
            exp_dwe  = wr_d[k];
            exp_addr = wr_a[k];
            exp_data = wr_w[k];
        end
        if (k == term_at) begin
            exp_ready = 1'b0; exp_done = 1'b1; exp_crst = 1'b0;
        end
        if (k == err_at) begin
            exp_ready = 1'b0; exp_err = 1'b1;
        end
    endfunction

    // Compare process: every output every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_ready});
            chk("imem_we",   {31'd0, imem_we},   {31'd0, exp_iwe});
            chk("dmem_we",   {31'd0, dmem_we},   {31'd0, exp_dwe});
            chk("mem_addr",  {24'd0, mem_addr},  {24'd0, exp_addr});
            chk("mem_wdata", mem_wdata,          exp_data);
            chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, exp_crst});
            chk("load_done", {31'd0, load_done}, {31'd0, exp_done});
            chk("load_err",  {31'd0, load_err},  {31'd0, exp_err});
        end
    end

    // Write log used for hand-computed literal checks.
    bit          log_d[$];
    logic [7:0]  log_a[$];
    logic [31:0] log_w[$];

    always @(negedge clk) begin
        if (checking && (imem_we || dmem_we)) begin
            log_d.push_back(dmem_we);
            log_a.push_back(mem_addr);
            log_w.push_back(mem_wdata);
        end
    end

    function automatic void log_clear();
        log_d.delete(); log_a.delete(); log_w.delete();
    endfunction

    // ---------------- drivers ----------------
    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic run_stream(input int gap, input int max_bytes);
        int k = 0;
        int idle = 0;
        parse();
        while (k < max_bytes && k < strm.size()) begin
            if (idle > 0) begin
                in_valid = 1'b0;
                idle--;
            end else begin
                in_valid = 1'b1;
                in_data  = strm[k];
            end
            @(posedge clk); #1;
            exp_iwe = 1'b0;
            exp_dwe = 1'b0;
            if (in_valid && exp_ready) begin
                accept(k);
                k++;
                idle = gap;
            end else if (in_valid) begin
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            exp_iwe = 1'b0;
            exp_dwe = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_reset();
        reset = 1'b0;
    endtask

    task automatic check_reset_literals();
        chk("rst in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst load_done", {31'd0, load_done}, 32'd0);
        chk("rst load_err",  {31'd0, load_err},  32'd0);
        chk("rst we",        {30'd0, imem_we, dmem_we}, 32'd0);
        chk("rst mem_addr",  {24'd0, mem_addr},  32'd0);
        chk("rst mem_wdata", mem_wdata,          32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_reset();
        reset    = 1'b0;
        checking = 1'b1;
        check_reset_literals();

        // Program load into imem.
        log_clear();
        strm = {8'h49, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h00, 8'h22, 8'h18, 8'h00,
                8'h04, 8'h22, 8'h20, 8'h00, 8'h00};
        run_stream(0, 64);
        idle_cycles(3);
        chk("prog n_writes", log_d.size(), 32'd2);
        if (log_d.size() == 2) begin
            chk("prog w0 data", log_w[0], 32'h00221800);
            chk("prog w0 addr", {24'd0, log_a[0]}, 32'd0);
            chk("prog w1 data", log_w[1], 32'h04222000);
            chk("prog w1 addr", {24'd0, log_a[1]}, 32'd1);
            chk("prog w1 dmem", {31'd0, log_d[1]}, 32'd0);
        end
        chk("prog load_done", {31'd0, load_done}, 32'd1);
        chk("prog cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // Second stream after RUN is refused.
        strm = {8'h49, 8'h00, 8'h00, 8'h00, 8'h01};
        run_stream(0, 64);
        idle_cycles(2);
        chk("run ignore n_writes", log_d.size(), 32'd2);

        // Data segment with three idle cycles between bytes.
        do_reset();
        log_clear();
        strm = {8'h44, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00};
        run_stream(3, 64);
        idle_cycles(4);
        chk("gap n_writes", log_d.size(), 32'd1);
        if (log_d.size() == 1) begin
            chk("gap dmem", {31'd0, log_d[0]}, 32'd1);
            chk("gap addr", {24'd0, log_a[0]}, 32'd1);
            chk("gap data", log_w[0], 32'd100);
        end

        // Out-of-bounds header.
        do_reset();
        log_clear();
        strm = {8'h49, 8'h00, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(0, 64);
        idle_cycles(3);
        chk("oob load_err",  {31'd0, load_err},  32'd1);
        chk("oob in_ready",  {31'd0, in_ready},  32'd0);
        chk("oob cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("oob n_writes",  log_d.size(),       32'd0);

        // Highest legal address, then an empty segment, then terminator.
        do_reset();
        log_clear();
        strm = {8'h49, 8'h00, 8'hFF, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h44, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        run_stream(0, 64);
        idle_cycles(2);
        chk("edge n_writes", log_d.size(), 32'd1);
        if (log_d.size() == 1) begin
            chk("edge addr", {24'd0, log_a[0]}, 32'd255);
            chk("edge data", log_w[0], 32'hDEADBEEF);
        end
        chk("edge load_done", {31'd0, load_done}, 32'd1);

        // Bad target, reset, then a normal reload.
        do_reset();
        log_clear();
        strm = {8'h5A};
        run_stream(0, 64);
        idle_cycles(2);
        chk("badtgt load_err", {31'd0, load_err}, 32'd1);
        do_reset();
        check_reset_literals();
        strm = {8'h49, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h22, 8'h18, 8'h00, 8'h00};
        run_stream(0, 64);
        idle_cycles(2);
        chk("reload n_writes", log_d.size(), 32'd1);
        chk("reload load_done", {31'd0, load_done}, 32'd1);

        // Reset after two data bytes; reload must produce the clean word.
        do_reset();
        log_clear();
        strm = {8'h44, 8'h00, 8'h05, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        run_stream(0, 7);
        do_reset();
        idle_cycles(2);
        chk("midword n_writes", log_d.size(), 32'd0);
        run_stream(0, 64);
        idle_cycles(2);
        chk("midword reload n", log_d.size(), 32'd1);
        if (log_d.size() == 1) begin
            chk("midword data", log_w[0], 32'hAABBCCDD);
            chk("midword addr", {24'd0, log_a[0]}, 32'd5);
        end

        // Reset on the same edge as the fourth data byte: no strobe.
        do_reset();
        log_clear();
        strm = {8'h49, 8'h00, 8'h03, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(0, 8);
        in_valid = 1'b1;
        in_data  = 8'h44;
        reset    = 1'b1;
        @(posedge clk); #1;
        exp_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        idle_cycles(3);
        chk("coinc n_writes", log_d.size(), 32'd0);
        run_stream(0, 64);
        idle_cycles(2);
        chk("coinc reload n", log_d.size(), 32'd1);
        if (log_d.size() == 1) begin
            chk("coinc data", log_w[0], 32'h11223344);
            chk("coinc addr", {24'd0, log_a[0]}, 32'd3);
        end

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
